kulisch_acc_to_fp16: RTL and testbench

//  Output stage downstream of the Kulisch accumulator in the tensor-core MMA path.

---
 rtl/kulisch_acc_to_fp16.sv | 182 ++++++++++++++++++
 tb/tb_kulisch_acc_to_fp16.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/kulisch_acc_to_fp16.sv
// rtl/kulisch_acc_to_fp16.sv - resolves a carry-save Kulisch accumulator pair to one FP16 result
//
// Purpose: final output stage of the tensor-core MMA path. The block adds the
// carry-save pair and takes its magnitude, finds the leading one, then
// normalises and rounds the value to nearest-even FP16. The result is held
// under a valid/ready handshake. Only one conversion is in flight at a time.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_valid/i_ready           input handshake; i_ready is high only in IDLE
//   i_sum_acc, i_carry_acc    carry-save words, value = (sum+carry) * 2^-FWIDTH
//   o_valid/o_ready           output handshake
//   o_result                  FP16 result
//   o_overflow                |rounded| >= 2^16, result is +/-inf
//   o_underflow               tiny before rounding and inexact
//   o_inexact                 rounding discarded nonzero bits
module kulisch_acc_to_fp16 #(
  parameter int AWIDTH = 92,
  parameter int FWIDTH = 48,
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [AWIDTH-1:0] i_sum_acc,
  input  logic [AWIDTH-1:0] i_carry_acc,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DWIDTH-1:0] o_result,
  output logic              o_overflow,
  output logic              o_underflow,
  output logic              o_inexact
);

  localparam int PW = $clog2(AWIDTH);
  // Bit index of weight 2^-24: the subnormal LSB.
  localparam int SUB_LSB = FWIDTH - 24;
  // Leading-one index of 2^-14: the smallest normal exponent.
  localparam int NORM_P_MIN = FWIDTH - 14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESOLVE,
    S_NORM,
    S_ROUND,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [AWIDTH-1:0] sum_q, carry_q, mag_q;
  logic              sign_q, zero_q;
  logic [PW-1:0]     p_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d = state_q;
    i_ready = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        i_ready = 1'b1;
        if (i_valid) state_d = S_RESOLVE;
      end
      S_RESOLVE: state_d = S_NORM;
      S_NORM:    state_d = S_ROUND;
      S_ROUND:   state_d = S_OUT;
      S_OUT: begin
        o_valid = 1'b1;
        if (o_ready) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Carry-propagate add; wraps mod 2^AWIDTH.
  logic [AWIDTH-1:0] acc;
  assign acc = sum_q + carry_q;

  // Leading-one detect: the highest set bit wins.
  logic [PW-1:0] lead_idx;
  always_comb begin
    lead_idx = '0;
    for (int i = 0; i < AWIDTH; i++) begin
      if (mag_q[i]) lead_idx = PW'(i);
    end
  end

  // Rounding. The LSB kept is 10 below the leading one, clamped to the 2^-24
  // position so tiny values come out subnormal.
  logic              is_norm;
  logic [PW-1:0]     lsb, lsb_m1;
  logic [10:0]       kept;
  logic              guard, sticky, rnd_up;
  logic [AWIDTH-1:0] sticky_mask;
  logic [11:0]       rounded;
  logic [17:0]       enc;
  logic              ovf_d, inx_d, unf_d;
  logic [DWIDTH-1:0] res_d;

  always_comb begin
    is_norm     = (p_q >= PW'(NORM_P_MIN));
    lsb         = is_norm ? (p_q - PW'(10)) : PW'(SUB_LSB);
    lsb_m1      = lsb - PW'(1);
    kept        = 11'(mag_q >> lsb);
    guard       = mag_q[lsb_m1];
    sticky_mask = (AWIDTH'(1) << lsb_m1) - AWIDTH'(1);
    sticky      = |(mag_q & sticky_mask);
    rnd_up      = guard & (sticky | kept[0]);
    rounded     = {1'b0, kept} + 12'(rnd_up);
    // The hidden bit of a normal adds one to the field (E-1)<<10, so a mantissa
    // carry-out lands in the exponent. A subnormal rounding up to 1024 becomes
    // 0x0400.
    if (is_norm) enc = ((18'(p_q) - 18'(NORM_P_MIN)) << 10) + 18'(rounded);
    else         enc = 18'(rounded);
    ovf_d = (enc >= 18'h07C00);
    inx_d = guard | sticky;
    unf_d = !is_norm && inx_d;
    if (zero_q) begin
      res_d = '0;
      ovf_d = 1'b0;
      inx_d = 1'b0;
      unf_d = 1'b0;
    end else if (ovf_d) begin
      res_d = {sign_q, 15'h7C00};
    end else begin
      res_d = {sign_q, enc[14:0]};
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      carry_q     <= '0;
      mag_q       <= '0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      p_q         <= '0;
      o_result    <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
      o_inexact   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            sum_q       <= i_sum_acc;
            carry_q     <= i_carry_acc;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
            o_inexact   <= 1'b0;
          end
        end
        S_RESOLVE: begin
          sign_q <= acc[AWIDTH-1];
          // The most-negative acc negates to 2^(AWIDTH-1) and overflows later.
          mag_q  <= acc[AWIDTH-1] ? (~acc + AWIDTH'(1)) : acc;
        end
        S_NORM: begin
          p_q    <= lead_idx;
          zero_q <= (mag_q == '0);
        end
        S_ROUND: begin
          o_result    <= res_d;
          o_overflow  <= ovf_d;
          o_underflow <= unf_d;
          o_inexact   <= inx_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kulisch_acc_to_fp16.sv
// tb/tb_kulisch_acc_to_fp16.sv - self-checking bench for kulisch_acc_to_fp16
module tb_kulisch_acc_to_fp16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [91:0] i_sum_acc;
  logic [91:0] i_carry_acc;
  logic        o_valid;
  logic        o_ready;
  logic [15:0] o_result;
  logic        o_overflow;
  logic        o_underflow;
  logic        o_inexact;

  kulisch_acc_to_fp16 dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .i_sum_acc   (i_sum_acc),
    .i_carry_acc (i_carry_acc),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_result    (o_result),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow),
    .o_inexact   (o_inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [91:0] sum;
    logic [91:0] carry;
    logic [15:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [91:0] neg(input logic [91:0] x);
    return ~x + 92'd1;
  endfunction

  function automatic logic [91:0] rnd92();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[91:0];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every output handshake pops one expected record.
  always @(negedge clk) begin
    if (!rst && o_valid && o_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 16'(o_valid), 16'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result",    o_result,           e.res);
        check("overflow",  16'(o_overflow),    16'(e.ovf));
        check("underflow", 16'(o_underflow),   16'(e.unf));
        check("inexact",   16'(o_inexact),     16'(e.inx));
      end
    end
  end

  task automatic wait_ready();
    int c = 0;
    while (!i_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (!i_ready) check("ready_timeout", 16'(i_ready), 16'd1);
  endtask

  // Drives one accepted input and pushes its expectation; operands are
  // scrambled right after the accept edge.
  task automatic send(input vec_t v);
    exp_t e;
    wait_ready();
    e.res = v.res; e.ovf = v.ovf; e.unf = v.unf; e.inx = v.inx;
    sb.push_back(e);
    i_valid     = 1'b1;
    i_sum_acc   = v.sum;
    i_carry_acc = v.carry;
    @(negedge clk);
    i_valid     = 1'b0;
    i_sum_acc   = rnd92();
    i_carry_acc = rnd92();
  endtask

  task automatic drain();
    int c = 0;
    while (sb.size() != 0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("drain_timeout", 16'(sb.size()), 16'd0);
  endtask

  initial begin
    logic [91:0] x;
    vec_t        v;

    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
    i_sum_acc = '0; i_carry_acc = '0;
    repeat (3) @(negedge clk);
    check("rst_i_ready",   16'(i_ready),     16'd1);
    check("rst_o_valid",   16'(o_valid),     16'd0);
    check("rst_result",    o_result,         16'h0000);
    check("rst_overflow",  16'(o_overflow),  16'd0);
    check("rst_underflow", 16'(o_underflow), 16'd0);
    check("rst_inexact",   16'(o_inexact),   16'd0);
    rst = 1'b0;
    @(negedge clk);

    // Latency: accept at edge N, o_valid visible in cycle N+4.
    v = '{92'd1 << 48, 92'd0, 16'h3C00, 1'b0, 1'b0, 1'b0};
    send(v);
    check("lat_busy_ready", 16'(i_ready), 16'd0);
    check("lat_n1", 16'(o_valid), 16'd0);
    @(negedge clk); check("lat_n2", 16'(o_valid), 16'd0);
    @(negedge clk); check("lat_n3", 16'(o_valid), 16'd0);
    @(negedge clk); check("lat_n4", 16'(o_valid), 16'd1);
    drain();

    x = 92'h123_4567_89AB_CDEF_0123;
    vecs.push_back('{92'd1 << 48, 92'd1 << 47, 16'h3E00, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{neg(92'd2 << 48), 92'd0, 16'hC000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{92'd65520 << 48, 92'd0, 16'h7C00, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{92'd65504 << 48, 92'd0, 16'h7BFF, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{92'd1 << 24, 92'd0, 16'h0001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{92'd1 << 23, 92'd0, 16'h0000, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{(92'd1 << 23) + 92'd1, 92'd0, 16'h0001, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{92'd1 << 91, 92'd0, 16'hFC00, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{x, neg(x), 16'h0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{neg(92'd1 << 23), 92'd0, 16'h8000, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{(92'd1 << 34) - 92'd1, 92'd0, 16'h0400, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{neg((92'd1 << 34) - 92'd1), 92'd0, 16'h8400, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{(92'd1 << 48) + (92'd1 << 37), 92'd0, 16'h3C00, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{(92'd1 << 48) + (92'd3 << 37), 92'd0, 16'h3C02, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{(92'd2 << 48) - (92'd1 << 37), 92'd0, 16'h4000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{92'd3 << 48, neg(92'd1 << 48), 16'h4000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{92'd1 << 63, 92'd0, 16'h7800, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{92'd1 << 34, 92'd0, 16'h0400, 1'b0, 1'b0, 1'b0});
    foreach (vecs[i]) send(vecs[i]);
    drain();

    // Backpressure: result held, i_valid ignored while busy.
    o_ready = 1'b0;
    v = '{92'd1 << 48, 92'd1 << 47, 16'h3E00, 1'b0, 1'b0, 1'b0};
    send(v);
    begin
      int c = 0;
      while (!o_valid && c < 20) begin
        @(negedge clk);
        c++;
      end
    end
    i_valid = 1'b1; i_sum_acc = 92'd7 << 48; i_carry_acc = '0;
    for (int k = 0; k < 10; k++) begin
      check("bp_o_valid",   16'(o_valid),     16'd1);
      check("bp_result",    o_result,         16'h3E00);
      check("bp_flags",     16'({o_overflow, o_underflow, o_inexact}), 16'd0);
      check("bp_i_ready",   16'(i_ready),     16'd0);
      @(negedge clk);
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    drain();
    repeat (8) begin
      @(negedge clk);
      check("bp_no_extra", 16'(o_valid), 16'd0);
    end

    // Reset while in NORM aborts with no output.
    wait_ready();
    i_valid = 1'b1; i_sum_acc = 92'd5 << 48; i_carry_acc = '0;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_i_ready", 16'(i_ready), 16'd1);
    check("mid_rst_o_valid", 16'(o_valid), 16'd0);
    check("mid_rst_result",  o_result,     16'h0000);
    repeat (8) begin
      @(negedge clk);
      check("mid_rst_no_out", 16'(o_valid), 16'd0);
    end

    // Still converts correctly after the abort.
    v = '{neg(92'd1 << 48), 92'd0, 16'hBC00, 1'b0, 1'b0, 1'b0};
    send(v);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
